ab_sweep_ctrl: RTL

Sequencer and checker for the two-input/two-output combinational logic blocks in the practice designs. On `start` it drives the four input combinations in order 00, 01, 10, 11 onto the block under control and holds each for a configurable number of cycles. It samples both outputs at the end of each hold, compares them against parameterised truth tables, and reports pass/fail, a per-vector failure mask and an error count. It replaces hand-written stimulus sequences wherever a logic block is instantiated on the board.

---
 rtl/ab_sweep_pkg.sv | 15 +
 rtl/ab_sweep_ctrl_hold_counter.sv | 41 ++++
 rtl/ab_sweep_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ab_sweep_pkg.sv
// Shared definitions for the A/B truth-table sweep controller:
// FSM state encoding and the widths of the vector index and hold counter.
package ab_sweep_pkg;

    localparam int IDX_W   = 2;
    localparam int CNT_W   = 4;
    localparam int NUM_VEC = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/ab_sweep_ctrl_hold_counter.sv
// Hold-time counter for the sweep controller. Counts cycles spent on the
// current vector and flags the cycle on which the vector must be sampled.
module hold_counter
    import ab_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic at_limit_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority so a new vector always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/ab_sweep_ctrl.sv
// Sweep controller for two-input/two-output logic blocks. Drives the four
// {A,B} combinations in order, holds each for HOLD_CYCLES cycles, samples the
// block's X/Y at the end of each hold and accumulates pass/fail results.
module ab_sweep_ctrl
    import ab_sweep_pkg::*;
#(
    parameter int         HOLD_CYCLES = 2,
    parameter logic [3:0] EXP_X       = 4'b0000,
    parameter logic [3:0] EXP_Y       = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       x_in,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       mask_q, mask_d;
    logic [2:0]       err_q, err_d;
    logic             pass_q, pass_d;

    logic             at_limit;
    logic             sample;
    logic             vec_mismatch;

    // The counter runs only while applying vectors and restarts per vector.
    hold_counter #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      ((state_q != APPLY) || at_limit),
        .en_i       (state_q == APPLY),
        .at_limit_o (at_limit)
    );

    assign sample       = (state_q == APPLY) && at_limit;
    assign vec_mismatch = (x_in != EXP_X[idx_q]) || (y_in != EXP_Y[idx_q]);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is honoured only in IDLE, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = APPLY;
            APPLY:   if (sample && (idx_q == LAST_IDX)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Vector index and result accumulation; pass is settled from the final
    // error count including a mismatch on the last vector.
    always_comb begin
        idx_d  = idx_q;
        mask_d = mask_q;
        err_d  = err_q;
        pass_d = pass_q;
        if ((state_q == IDLE) && start) begin
            idx_d  = '0;
            mask_d = '0;
            err_d  = '0;
            pass_d = 1'b0;
        end else if (sample) begin
            if (vec_mismatch) begin
                mask_d[idx_q] = 1'b1;
                err_d         = err_q + 3'd1;
            end
            if (idx_q == LAST_IDX) begin
                idx_d  = '0;
                pass_d = (err_d == 3'd0);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Index and result registers; the index doubles as the registered A/B drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            mask_q <= '0;
            err_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            mask_q <= mask_d;
            err_q  <= err_d;
            pass_q <= pass_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        busy = (state_q == APPLY);
        done = (state_q == DONE);
    end

    assign a_out     = idx_q[1];
    assign b_out     = idx_q[0];
    assign pass      = pass_q;
    assign fail_mask = mask_q;
    assign err_count = err_q;

endmodule
